// File: rtl/laser_pinball_pkg.sv
// Shared types and constants for the laser pinball marker pipeline.
// Contents: coordinate width, NOT_FOUND sentinel default, colour indices,
// marker_filter FSM state encoding and the packed (x,y) coordinate payload.
package laser_pinball_pkg;

  localparam int unsigned COORD_W     = 9;
  localparam int unsigned NUM_COLOURS = 3;

  localparam logic [COORD_W-1:0] NOT_FOUND_DEFAULT = 9'h1FF;

  localparam logic [1:0] COL_RED   = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROC_R,
    ST_PROC_G,
    ST_PROC_B,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

endpackage

// File: rtl/axis_smoother.sv
// Per-axis filter arithmetic: signed difference, jump detect, shift-add smoothing.
// Ports:
//   raw_i       raw coordinate for this axis
//   filt_i      current filtered coordinate for this axis
//   jump_c_o    |raw - filt| > JUMP_MAX (combinational)
//   smooth_c_o  filt + ((raw - filt) >>> SHIFT), truncated to COORD_W (combinational)
module axis_smoother
  import laser_pinball_pkg::*;
#(
  parameter int unsigned        SHIFT    = 2,
  parameter logic [COORD_W-1:0] JUMP_MAX = 9'd64
) (
  input  logic [COORD_W-1:0] raw_i,
  input  logic [COORD_W-1:0] filt_i,
  output logic               jump_c_o,
  output logic [COORD_W-1:0] smooth_c_o
);

  localparam int unsigned DW = COORD_W + 1;

  logic signed [DW-1:0] diff;
  logic        [DW-1:0] mag;
  logic signed [DW-1:0] step;

  // Arithmetic shift floors toward minus infinity; result stays in 0..510.
  always_comb begin
    diff       = $signed({1'b0, raw_i}) - $signed({1'b0, filt_i});
    mag        = diff[DW-1] ? $unsigned(-diff) : $unsigned(diff);
    jump_c_o   = (mag > {1'b0, JUMP_MAX});
    step       = diff >>> SHIFT;
    smooth_c_o = COORD_W'($unsigned(step) + {1'b0, filt_i});
  end

endmodule

// File: rtl/marker_filter.sv
// Marker coordinate filter: captures one frame of raw red/green/blue marker
// positions, runs each colour through a shared smoothing datapath (one colour
// per cycle), and publishes filtered positions plus per-colour lost flags.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   hunt_done             capture strobe; raw coordinates valid same cycle
//   red/green/blue_x/y    raw coordinates (NOT_FOUND = no marker)
//   filt_*_x/y            filtered coordinates
//   filt_valid            one-cycle pulse when filtered outputs update
//   lost                  per-colour lost flag {blue, green, red}
//   busy                  high from capture through the filt_valid cycle
module marker_filter
  import laser_pinball_pkg::*;
#(
  parameter int unsigned        SHIFT       = 2,
  parameter logic [COORD_W-1:0] JUMP_MAX    = 9'd64,
  parameter int unsigned        PERSIST     = 3,
  parameter int unsigned        LOST_FRAMES = 4,
  parameter logic [COORD_W-1:0] NOT_FOUND   = NOT_FOUND_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hunt_done,
  input  logic [COORD_W-1:0]     red_x,
  input  logic [COORD_W-1:0]     red_y,
  input  logic [COORD_W-1:0]     green_x,
  input  logic [COORD_W-1:0]     green_y,
  input  logic [COORD_W-1:0]     blue_x,
  input  logic [COORD_W-1:0]     blue_y,
  output logic [COORD_W-1:0]     filt_red_x,
  output logic [COORD_W-1:0]     filt_red_y,
  output logic [COORD_W-1:0]     filt_green_x,
  output logic [COORD_W-1:0]     filt_green_y,
  output logic [COORD_W-1:0]     filt_blue_x,
  output logic [COORD_W-1:0]     filt_blue_y,
  output logic                   filt_valid,
  output logic [NUM_COLOURS-1:0] lost,
  output logic                   busy
);

  localparam int unsigned JW = $clog2(PERSIST + 1);
  localparam int unsigned MW = $clog2(LOST_FRAMES + 1);

  state_t        state_q;
  logic          busy_q;
  logic          valid_q;
  coord_t        raw_q  [NUM_COLOURS];
  coord_t        filt_q [NUM_COLOURS];
  logic          init_q [NUM_COLOURS];
  logic          lost_q [NUM_COLOURS];
  logic [MW-1:0] miss_q [NUM_COLOURS];
  logic [JW-1:0] jump_q [NUM_COLOURS];

  logic [1:0]    col;
  coord_t        cur_raw;
  coord_t        cur_filt;
  coord_t        filt_d;
  logic          init_d;
  logic          lost_d;
  logic [MW-1:0] miss_d;
  logic [JW-1:0] jump_d;
  logic [JW-1:0] jump_inc;
  logic          is_miss;
  logic          jump_x;
  logic          jump_y;
  logic [COORD_W-1:0] smooth_x;
  logic [COORD_W-1:0] smooth_y;

  // Colour served by the shared datapath this cycle.
  always_comb begin
    col = COL_RED;
    case (state_q)
      ST_PROC_G: col = COL_GREEN;
      ST_PROC_B: col = COL_BLUE;
      default:   col = COL_RED;
    endcase
  end

  assign cur_raw  = raw_q[col];
  assign cur_filt = filt_q[col];

  axis_smoother #(.SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_axis_x (
    .raw_i      (cur_raw.x),
    .filt_i     (cur_filt.x),
    .jump_c_o   (jump_x),
    .smooth_c_o (smooth_x)
  );

  axis_smoother #(.SHIFT(SHIFT), .JUMP_MAX(JUMP_MAX)) u_axis_y (
    .raw_i      (cur_raw.y),
    .filt_i     (cur_filt.y),
    .jump_c_o   (jump_y),
    .smooth_c_o (smooth_y)
  );

  // Next per-colour state for the colour currently being processed.
  always_comb begin
    filt_d   = cur_filt;
    init_d   = init_q[col];
    lost_d   = lost_q[col];
    miss_d   = miss_q[col];
    jump_d   = jump_q[col];
    jump_inc = jump_q[col] + JW'(1);
    is_miss  = (cur_raw.x == NOT_FOUND) || (cur_raw.y == NOT_FOUND);

    if (is_miss) begin
      if (miss_q[col] < MW'(LOST_FRAMES)) miss_d = miss_q[col] + MW'(1);
      if (miss_d == MW'(LOST_FRAMES))     lost_d = 1'b1;
      jump_d = '0;
    end else begin
      miss_d = '0;
      lost_d = 1'b0;
      if (!init_q[col] || lost_q[col]) begin
        // Fresh or reacquired marker: snap to the raw position.
        filt_d = cur_raw;
        init_d = 1'b1;
        jump_d = '0;
      end else if (jump_x || jump_y) begin
        // Large steps are only believed once they persist.
        if (jump_inc == JW'(PERSIST)) begin
          filt_d = cur_raw;
          jump_d = '0;
        end else begin
          jump_d = jump_inc;
        end
      end else begin
        jump_d = '0;
        filt_d = '{x: smooth_x, y: smooth_y};
      end
    end
  end

  // Sequencer, per-colour state arrays and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      raw_q        <= '{default: '0};
      filt_q       <= '{default: '0};
      init_q       <= '{default: 1'b0};
      lost_q       <= '{default: 1'b1};
      miss_q       <= '{default: '0};
      jump_q       <= '{default: '0};
      filt_red_x   <= '0;
      filt_red_y   <= '0;
      filt_green_x <= '0;
      filt_green_y <= '0;
      filt_blue_x  <= '0;
      filt_blue_y  <= '0;
      lost         <= '1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // busy is still high during the filt_valid cycle, so a strobe
          // landing there is dropped.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (hunt_done) begin
            raw_q[COL_RED]   <= '{x: red_x,   y: red_y};
            raw_q[COL_GREEN] <= '{x: green_x, y: green_y};
            raw_q[COL_BLUE]  <= '{x: blue_x,  y: blue_y};
            busy_q           <= 1'b1;
            state_q          <= ST_PROC_R;
          end
        end
        ST_PROC_R, ST_PROC_G, ST_PROC_B: begin
          filt_q[col] <= filt_d;
          init_q[col] <= init_d;
          lost_q[col] <= lost_d;
          miss_q[col] <= miss_d;
          jump_q[col] <= jump_d;
          case (state_q)
            ST_PROC_R: state_q <= ST_PROC_G;
            ST_PROC_G: state_q <= ST_PROC_B;
            default:   state_q <= ST_OUT;
          endcase
        end
        ST_OUT: begin
          filt_red_x   <= filt_q[COL_RED].x;
          filt_red_y   <= filt_q[COL_RED].y;
          filt_green_x <= filt_q[COL_GREEN].x;
          filt_green_y <= filt_q[COL_GREEN].y;
          filt_blue_x  <= filt_q[COL_BLUE].x;
          filt_blue_y  <= filt_q[COL_BLUE].y;
          lost         <= {lost_q[COL_BLUE], lost_q[COL_GREEN], lost_q[COL_RED]};
          valid_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign filt_valid = valid_q;
  assign busy       = busy_q;

endmodule
